main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter MEM_BLOCKS, default 4096, number of blocks stored; SHALL equal 2**BLOCK_ADDR_WIDTH.
REQ-002 Parameter BLOCK_ADDR_WIDTH, default 12, width of the block address ({tag,set} low bits).
REQ-003 Parameter DATA_WIDTH, default 32, word width.
REQ-004 Parameter OFFSET_WIDTH, default 4; WORDS_PER_BLOCK = 1 << OFFSET_WIDTH.
REQ-005 Parameter READ_LATENCY, default 4, idle cycles between read-request acceptance and the first read word; SHALL be at least 1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  cache presents a block request.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 req_write  input  1  1 = write-back of a victim block, 0 = refill read.
REQ-011 req_block_addr  input  BLOCK_ADDR_WIDTH  block index of the request.
REQ-012 wdata_valid  input  1  write-back word present.
REQ-013 wdata  input  DATA_WIDTH  write-back word, sent in offset order 0..WORDS_PER_BLOCK-1.
REQ-014 wdata_ready  output  1  responder accepts a write-back word.
REQ-015 rdata_valid  output  1  refill word present.
REQ-016 rdata  output  DATA_WIDTH  refill word, sent in offset order 0..WORDS_PER_BLOCK-1.
REQ-017 rdata_last  output  1  marks offset WORDS_PER_BLOCK-1 of a refill.
REQ-018 rdata_ready  input  1  cache accepts the refill word.
REQ-019 done  output  1  one-cycle pulse after a transaction completes.

Function
REQ-020 The FSM SHALL have states IDLE, READ_WAIT, READ_BURST, WRITE_BURST, DONE.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, latching req_write and req_block_addr.
REQ-022 On an accepted write: IDLE -> WRITE_BURST, word counter = 0.
REQ-023 On an accepted read: IDLE -> READ_WAIT, latency counter = READ_LATENCY-1.
REQ-024 READ_WAIT: counter decrements each cycle; at counter 0 -> READ_BURST with word counter = 0; first rdata_valid appears exactly READ_LATENCY cycles after the acceptance edge.
REQ-025 READ_BURST: rdata_valid = 1, rdata = memory[latched addr][word counter], rdata_last = (counter == WORDS_PER_BLOCK-1); counter advances only when rdata_ready = 1; rdata SHALL stay stable while rdata_ready = 0.
REQ-026 Last refill word accepted -> DONE.
REQ-027 WRITE_BURST: wdata_ready = 1; each cycle with wdata_valid = 1 stores wdata to memory[latched addr][word counter] and advances the counter; cycles with wdata_valid = 0 store nothing.
REQ-028 Last write-back word stored -> DONE; the written block SHALL be readable by the next request.
REQ-029 DONE: done = 1 for exactly one cycle, all other handshake outputs 0, then -> IDLE.
REQ-030 Word counter width SHALL be OFFSET_WIDTH and SHALL NOT wrap inside a burst; burst length is always WORDS_PER_BLOCK.
REQ-031 Outside their states, rdata_valid, rdata_last and wdata_ready SHALL be 0; rdata SHALL be 0 when rdata_valid = 0.
REQ-032 Requests presented outside IDLE SHALL be ignored (not queued); inputs not relevant to the current state are ignored.

Reset
REQ-033 With reset high at a rising edge: state = IDLE, all counters 0, latched address/write flag 0, done = 0, rdata_valid = 0, wdata_ready = 0, req_ready = 1 in the following cycle.
REQ-034 Reset mid-transaction SHALL abort it with no done pulse; words already stored by a partial write-back remain in memory.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset SHALL take priority over any simultaneous handshake.

Verification
REQ-037 Write-back block 0x0A5, words 0x100+i, wdata_valid held high -> 16 stores in 16 cycles, done pulses once, back to IDLE.
REQ-038 Read block 0x0A5 after REQ-037, rdata_ready held high -> first rdata_valid 4 cycles after acceptance, rdata 0x100..0x10F, rdata_last only on 0x10F, then done.
REQ-039 Read with rdata_ready low for 3 cycles on word 5 -> rdata holds 0x105 those cycles, no word skipped or repeated.
REQ-040 Write-back with wdata_valid gaps on every other cycle -> exactly 16 words stored in order, done after 32 cycles.
REQ-041 req_valid asserted during READ_BURST with a different address -> ignored; the current burst completes unchanged.
REQ-042 Reset asserted after 7 write-back words -> no done pulse, IDLE next cycle; a subsequent read returns the 7 new words followed by the old contents.

Source files
------------

// File: rtl/main_mem_responder.sv
// Block-granular main-memory model answering cache refill reads and victim write-backs.
// One transaction at a time: request handshake, fixed read latency, then a 1<<OFFSET_WIDTH word burst.
module main_mem_responder #(
  parameter int unsigned MEM_BLOCKS       = 4096,
  parameter int unsigned BLOCK_ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned OFFSET_WIDTH     = 4,
  parameter int unsigned READ_LATENCY     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [BLOCK_ADDR_WIDTH-1:0] req_block_addr,
  input  logic                        wdata_valid,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic                        wdata_ready,
  output logic                        rdata_valid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rdata_last,
  input  logic                        rdata_ready,
  output logic                        done
);

  localparam int unsigned WORDS_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int unsigned MEM_AW          = BLOCK_ADDR_WIDTH + OFFSET_WIDTH;
  localparam int unsigned LAT_W           = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]        LAT_INIT  = LAT_W'(READ_LATENCY - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_BURST,
    WRITE_BURST,
    DONE
  } state_t;

  state_t                      state;
  state_t                      next_state;
  logic [LAT_W-1:0]            lat_cnt;
  logic [OFFSET_WIDTH-1:0]     word_cnt;
  logic [BLOCK_ADDR_WIDTH-1:0] blk_addr;
  logic                        wr_flag;
  logic [MEM_AW-1:0]           mem_idx;
  logic                        mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_BLOCKS*WORDS_PER_BLOCK];

  assign mem_idx = {blk_addr, word_cnt};
  // Reset blocks the store so a reset coinciding with a write-back word wins.
  assign mem_we  = !reset && (state == WRITE_BURST) && wr_flag && wdata_valid;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      word_cnt <= '0;
      blk_addr <= '0;
      wr_flag  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            blk_addr <= req_block_addr;
            wr_flag  <= req_write;
            word_cnt <= '0;
            lat_cnt  <= req_write ? '0 : LAT_INIT;
          end
        end
        READ_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            word_cnt <= '0;
          end
        end
        READ_BURST: begin
          if (rdata_ready) begin
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + OFFSET_WIDTH'(1);
          end
        end
        WRITE_BURST: begin
          if (wdata_valid) begin
            word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + OFFSET_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (req_valid) next_state = req_write ? WRITE_BURST : READ_WAIT;
      READ_WAIT:   if (lat_cnt == '0) next_state = READ_BURST;
      READ_BURST:  if (rdata_ready && (word_cnt == LAST_WORD)) next_state = DONE;
      WRITE_BURST: if (wdata_valid && (word_cnt == LAST_WORD)) next_state = DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    rdata       = '0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:        req_ready = 1'b1;
      READ_BURST: begin
        rdata_valid = 1'b1;
        rdata_last  = (word_cnt == LAST_WORD);
        rdata       = mem[mem_idx];
      end
      WRITE_BURST: wdata_ready = 1'b1;
      DONE:        done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: reference memory model plus a refill-word scoreboard.
module tb_main_mem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned OW  = 4;
  localparam int unsigned WPB = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_block_addr;
  logic          wdata_valid;
  logic [DW-1:0] wdata;
  logic          wdata_ready;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          rdata_last;
  logic          rdata_ready;
  logic          done;

  main_mem_responder #(
    .MEM_BLOCKS      (4096),
    .BLOCK_ADDR_WIDTH(AW),
    .DATA_WIDTH      (DW),
    .OFFSET_WIDTH    (OW),
    .READ_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_block_addr(req_block_addr),
    .wdata_valid   (wdata_valid),
    .wdata         (wdata),
    .wdata_ready   (wdata_ready),
    .rdata_valid   (rdata_valid),
    .rdata         (rdata),
    .rdata_last    (rdata_last),
    .rdata_ready   (rdata_ready),
    .done          (done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] ref_mem [bit [AW+OW-1:0]];
  logic [AW-1:0] wr_addr = '0;
  logic [OW-1:0] wr_cnt = '0;
  int unsigned   done_count = 0;
  logic          mon_en = 1'b0;
  logic          stalled = 1'b0;
  logic [DW-1:0] stall_val = '0;

  // Negedge monitor: models stores, pops expected refill words, checks hold-while-stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) done_count++;
      if (!rdata_valid) check("rdata_zero_when_idle", 64'(rdata), 64'(0));
      if (stalled && rdata_valid) check("rdata_stable", 64'(rdata), 64'(stall_val));
      stalled   = rdata_valid && !rdata_ready;
      stall_val = rdata;
      if (rdata_valid && rdata_ready) begin
        if (sb.size() == 0) begin
          check("rdata_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("rdata", 64'(rdata), 64'(e.data));
          check("rdata_last", 64'(rdata_last), 64'(e.last));
        end
      end
      if (!reset && wdata_valid && wdata_ready) begin
        ref_mem[{wr_addr, wr_cnt}] = wdata;
        wr_cnt++;
      end
    end
  end

  // Entered at #1 after a posedge with the DUT idle; returns #1 after the acceptance edge.
  task automatic start_req(input logic wr, input logic [AW-1:0] a);
    req_valid      = 1'b1;
    req_write      = wr;
    req_block_addr = a;
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic finish_txn(input string tag, input int unsigned d0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_quiet"}, 64'({rdata_valid, wdata_ready, req_ready}), 64'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(req_ready), 64'(1));
    check({tag, "_done_count"}, 64'(done_count - d0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic write_block(input logic [AW-1:0] a, input logic [DW-1:0] base,
                             input bit gap, input int unsigned abort_at);
    int unsigned d0 = done_count;
    int unsigned i = 0;
    int unsigned cyc = 0;
    bit acc;
    bit aborted = 1'b0;
    wr_addr = a;
    wr_cnt  = '0;
    start_req(1'b1, a);
    while (i < WPB && cyc < 200) begin
      if (i == abort_at) begin
        reset       = 1'b1;
        wdata_valid = 1'b1;
        wdata       = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      wdata_valid = !(gap && (cyc % 2 == 0));
      wdata       = base + i;
      @(negedge clk);
      check("wdata_ready", 64'(wdata_ready), 64'(1));
      acc = wdata_valid && wdata_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    wdata_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'(0));
      check("abort_idle", 64'(req_ready), 64'(1));
      check("abort_wdata_ready", 64'(wdata_ready), 64'(0));
      check("abort_done_count", 64'(done_count - d0), 64'(0));
      @(posedge clk); #1;
    end else begin
      check("wr_cycles", 64'(cyc), gap ? 64'(2 * WPB) : 64'(WPB));
      finish_txn("wr", d0);
    end
  endtask

  task automatic read_block(input logic [AW-1:0] a, input int unsigned stall_word,
                            input bit intrude, input bit rnd);
    int unsigned d0 = done_count;
    int unsigned n = 0;
    int unsigned w = 0;
    int unsigned stalls = 0;
    int unsigned guard = 0;
    bit acc;
    for (int unsigned k = 0; k < WPB; k++) begin
      sb.push_back(exp_t'{data: ref_mem[{a, OW'(k)}], last: (k == WPB - 1)});
    end
    rdata_ready = 1'b0;
    start_req(1'b0, a);
    while (!rdata_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_latency", 64'(n), 64'(LAT));
    if (intrude) begin
      req_valid      = 1'b1;
      req_write      = 1'b1;
      req_block_addr = a ^ 12'hFFF;
    end
    while (w < WPB && guard < 200) begin
      if (w == stall_word && stalls < 3) begin
        rdata_ready = 1'b0;
        stalls++;
      end else begin
        rdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      acc = rdata_valid && rdata_ready;
      if (intrude) check("intrude_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      if (acc) w++;
      guard++;
    end
    rdata_ready = 1'b0;
    req_valid   = 1'b0;
    if (!rnd) check("rd_cycles", 64'(guard), 64'(WPB + ((stall_word < WPB) ? 3 : 0)));
    finish_txn("rd", d0);
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rb;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_block_addr = '0;
    wdata_valid    = 1'b0;
    wdata          = '0;
    rdata_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_outputs", 64'({rdata_valid, wdata_ready, rdata_last, done}), 64'(0));
    @(posedge clk); #1;

    write_block(12'h0A5, 32'h100, 1'b0, 99);
    read_block(12'h0A5, 99, 1'b0, 1'b0);
    read_block(12'h0A5, 5, 1'b0, 1'b0);
    read_block(12'h0A5, 99, 1'b1, 1'b0);

    write_block(12'h3C0, 32'h200, 1'b1, 99);
    read_block(12'h3C0, 99, 1'b0, 1'b0);

    write_block(12'h0A5, 32'h500, 1'b0, 7);
    read_block(12'h0A5, 99, 1'b0, 1'b0);

    for (int unsigned t = 0; t < 3; t++) begin
      ra = AW'($urandom_range(0, 4095));
      rb = $urandom;
      write_block(ra, rb, t[0], 99);
      read_block(ra, 99, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
